// File: rtl/walu_mc.sv
// Multicycle ALU responder: one request in flight, single-cycle ops plus an iterative shift-add multiplier.
// Optional overflow flag output enabled by defining WALU_MC_OVF_EN.
module walu_mc #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err
`ifdef WALU_MC_OVF_EN
  ,
  output logic                  rsp_ovf
`endif
);

  localparam int unsigned HW = DATA_WIDTH / 2;
  localparam int unsigned SW = $clog2(DATA_WIDTH);
  localparam int unsigned CW = $clog2(HW + 1);
  localparam int unsigned MSB = DATA_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MULT = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
    OP_XOR = 4'd5, OP_LSL = 4'd6, OP_LSR = 4'd7, OP_RL = 4'd8, OP_RR = 4'd9
  } op_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mcand_q, acc_q;
  logic [HW-1:0]         mplier_q;
  logic [CW-1:0]         cnt_q;
  logic                  accept;
  logic [SW-1:0]         sh;
  logic [DATA_WIDTH-1:0] sum, diff, alu_res, acc_next;
  logic                  alu_err;
`ifdef WALU_MC_OVF_EN
  logic                  alu_ovf, mul_ovf_q;
  logic [HW-1:0]         cross;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) state_d = (req_op == OP_MULT) ? MUL : DONE;
      end
      MUL:  if (cnt_q == CW'(1)) state_d = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    sh      = req_b[SW-1:0];
    sum     = req_a + req_b;
    diff    = req_a - req_b;
    alu_res = '0;
    alu_err = 1'b0;
`ifdef WALU_MC_OVF_EN
    alu_ovf = 1'b0;
    // The truncated full product differs from the half product exactly when
    // the cross terms a_hi*b_lo + a_lo*b_hi are nonzero modulo 2^HW.
    cross   = req_a[DATA_WIDTH-1:HW] * req_b[HW-1:0] + req_a[HW-1:0] * req_b[DATA_WIDTH-1:HW];
`endif
    case (op_e'(req_op))
      OP_ADD: begin
        alu_res = sum;
`ifdef WALU_MC_OVF_EN
        alu_ovf = (req_a[MSB] == req_b[MSB]) && (sum[MSB] != req_a[MSB]);
`endif
      end
      OP_SUB: begin
        alu_res = diff;
`ifdef WALU_MC_OVF_EN
        alu_ovf = (req_a[MSB] != req_b[MSB]) && (diff[MSB] != req_a[MSB]);
`endif
      end
      OP_MULT: begin
`ifdef WALU_MC_OVF_EN
        alu_ovf = |cross;
`endif
      end
      OP_AND:  alu_res = req_a & req_b;
      OP_OR:   alu_res = req_a | req_b;
      OP_XOR:  alu_res = req_a ^ req_b;
      OP_LSL:  alu_res = req_a << sh;
      OP_LSR:  alu_res = req_a >> sh;
      OP_RL:   alu_res = DATA_WIDTH'(({req_a, req_a} << sh) >> DATA_WIDTH);
      OP_RR:   alu_res = DATA_WIDTH'({req_a, req_a} >> sh);
      default: alu_err = 1'b1;
    endcase
  end

  assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
`ifdef WALU_MC_OVF_EN
      mul_ovf_q <= 1'b0;
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          if (req_op == OP_MULT) begin
            mcand_q   <= {{HW{1'b0}}, req_a[HW-1:0]};
            mplier_q  <= req_b[HW-1:0];
            acc_q     <= '0;
            cnt_q     <= CW'(HW);
`ifdef WALU_MC_OVF_EN
            mul_ovf_q <= alu_ovf;
`endif
          end else begin
            rsp_data <= alu_res;
            rsp_err  <= alu_err;
`ifdef WALU_MC_OVF_EN
            rsp_ovf  <= alu_ovf;
`endif
          end
        end
        MUL: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          // Final iteration's partial sum goes straight to the result register.
          if (cnt_q == CW'(1)) begin
            rsp_data <= acc_next;
            rsp_err  <= 1'b0;
`ifdef WALU_MC_OVF_EN
            rsp_ovf  <= mul_ovf_q;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_walu_mc.sv
// Directed self-checking bench for walu_mc at DATA_WIDTH=32; covers rsp_ovf when WALU_MC_OVF_EN is defined.
module tb_walu_mc;

  logic        clk, rst_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b, rsp_data;
`ifdef WALU_MC_OVF_EN
  logic        rsp_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  walu_mc #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
`ifdef WALU_MC_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int NV = 10;
  localparam logic [3:0]  T_OP  [NV] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9};
  localparam logic [31:0] T_A   [NV] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0005,
                                         32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001,
                                         32'h8000_0001, 32'h8000_0001};
  localparam logic [31:0] T_B   [NV] = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 32'h0000_0007,
                                         32'h0000_0021, 32'h0000_0021, 32'h0000_0021, 32'h0000_0021,
                                         32'h0000_0021, 32'h0000_0021};
  localparam logic [31:0] T_EXP [NV] = '{32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE,
                                         32'h0000_0001, 32'h8000_0021, 32'h0000_0002, 32'h4000_0000,
                                         32'h0000_0003, 32'hC000_0000};
  localparam logic        T_OVF [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Presents one request at posedge+1 and returns at posedge+1 right after the accept edge,
  // with the request inputs scrambled so later changes must be ignored.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'hE; req_a = 32'h5A5A_A5A5; req_b = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset;
    #3;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready/valid/err=%b data=%h required 000 00000000",
               {req_ready, rsp_valid, rsp_err}, rsp_data);
    end
`ifdef WALU_MC_OVF_EN
    n_checks++;
    if (rsp_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", rsp_ovf); end
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_single_cycle_ops;
    for (int i = 0; i < NV; i++) begin
      issue(T_OP[i], T_A[i], T_B[i]);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== T_EXP[i] || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL op_%0d vec%0d: valid=%b data=%h err=%b ready=%b required 1 %h 0 0",
                 T_OP[i], i, rsp_valid, rsp_data, rsp_err, req_ready, T_EXP[i]);
      end
`ifdef WALU_MC_OVF_EN
      n_checks++;
      if (rsp_ovf !== T_OVF[i]) begin
        n_fail++;
        $display("FAIL ovf vec%0d: got %b required %b", i, rsp_ovf, T_OVF[i]);
      end
`endif
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL handshake_release vec%0d: valid=%b ready=%b required 0 1", i, rsp_valid, req_ready);
      end
    end
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic exp_ovf);
    logic early = 1'b0;
    issue(4'd2, a, b);
    for (int k = 0; k < 16; k++) begin
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) early = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (early) begin
      n_fail++;
      $display("FAIL mult_busy: valid/ready went high during iterations, required both 0 for 16 cycles");
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_result a=%h b=%h: valid=%b data=%h err=%b required 1 %h 0",
               a, b, rsp_valid, rsp_data, rsp_err, exp);
    end
`ifdef WALU_MC_OVF_EN
    n_checks++;
    if (rsp_ovf !== exp_ovf) begin n_fail++; $display("FAIL mult_ovf: got %b required %b", rsp_ovf, exp_ovf); end
`else
    if (exp_ovf === 1'bx) $display("note: unknown ovf expectation");
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    run_mult(32'hABCD_1234, 32'h0000_0100, 32'h0012_3400, 1'b1);
    run_mult(32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0);
  endtask

  task automatic test_error_op;
    issue(4'd12, 32'hDEAD_BEEF, 32'h1234_5678);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0 || rsp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_op: valid=%b data=%h err=%b required 1 00000000 1", rsp_valid, rsp_data, rsp_err);
    end
    @(posedge clk); #1;
    issue(4'd1, 32'h0000_0005, 32'h0000_0007);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFE || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_after_err: valid=%b data=%h err=%b required 1 fffffffe 0", rsp_valid, rsp_data, rsp_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    issue(4'd5, 32'hF0F0_F0F0, 32'hFFFF_0000);
    req_valid = 1'b1; req_op = 4'd0; req_a = 32'h1; req_b = 32'h1;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0F0F_F0F0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold cycle%0d: valid=%b data=%h ready=%b required 1 0f0ff0f0 0",
                 k, rsp_valid, rsp_data, req_ready);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_mult;
    logic spurious = 1'b0;
    issue(4'd2, 32'h0000_00FF, 32'h0000_00FF);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_mult_reset: valid=%b ready=%b data=%h required 0 0 00000000",
               rsp_valid, req_ready, rsp_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid !== 1'b0) spurious = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (spurious) begin
      n_fail++;
      $display("FAIL aborted_mult_response: rsp_valid rose, required to stay 0");
    end
    issue(4'd0, 32'h1, 32'h1);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h2 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL add_after_reset: valid=%b data=%h err=%b required 1 00000002 0", rsp_valid, rsp_data, rsp_err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    test_reset();
    test_single_cycle_ops();
    test_mult();
    test_error_op();
    test_backpressure();
    test_reset_mid_mult();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/walu_mc.md
# walu_mc

Multicycle ALU responder for the `walu` environment: accepts one operation request at a time (operation code plus two `DATA_WIDTH` operands) over a valid/ready handshake, executes it, and returns the result over a second valid/ready handshake. Single-cycle operations complete in one cycle; `mult` runs an iterative shift-add multiplier. It is the executing end of the request stream produced by the `walu` driver, and its results feed the scoreboard monitor.

## Interface
- `DATA_WIDTH`, default 32: operand/result width; must be even and at least 4.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  4  operation code (`walu_pkg::op_t` encoding: add=0 … funcrr=9).
- `req_a`, `req_b`  in  DATA_WIDTH each  operands.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  DATA_WIDTH  result.
- `rsp_err`  out  1  request carried an unsupported op code (10–15).

## Operation
- FSM states: IDLE, MUL, DONE. Reset → IDLE.
- IDLE: `req_ready`=1. Request accepted when `req_valid && req_ready`. Operands and op are latched at acceptance; later changes on the req_* inputs are ignored.
  - `mult` → MUL; load multiplicand = `req_a[DATA_WIDTH/2-1:0]`, multiplier = `req_b[DATA_WIDTH/2-1:0]`, accumulator = 0, counter = DATA_WIDTH/2.
  - Any other code → compute the result in the same cycle, register it, go to DONE.
- Arithmetic and width rules (results truncated to DATA_WIDTH):
  - add: a+b mod 2^DATA_WIDTH.
  - sub: a−b mod 2^DATA_WIDTH.
  - mult: unsigned product of the lower halves, full DATA_WIDTH; the upper halves of the operands are ignored.
  - bitand/bitor/bitxor: bitwise.
  - funclsl/funclsr: logical shift of a by `b[$clog2(DATA_WIDTH)-1:0]`; the higher bits of b are ignored.
  - funcrl/funcrr: rotate a left/right by the same amount.
  - Codes 10–15: `rsp_data`=0, `rsp_err`=1.
- MUL: `req_ready`=0. Each cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator; shift the multiplicand left by 1 and the multiplier right by 1; decrement the counter. After the DATA_WIDTH/2 iteration the product is registered and the FSM goes to DONE.
- DONE: `rsp_valid`=1. `rsp_data` and `rsp_err` are stable until the handshake. On `rsp_ready` → IDLE. A backpressured result is held indefinitely.
- No request is accepted in MUL or DONE. There is no accept-in-DONE bypass; the block has one transaction in flight.
- `rsp_err`=0 for every supported op.

## Timing
- Reset values: `req_ready`=0 while `rst_n`=0, then 1 from the first edge in IDLE (combinational from state). `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0.
- Latency from the accept edge to `rsp_valid`=1:
  - Non-mult: 1 cycle.
  - mult: DATA_WIDTH/2 + 1 cycles (17 at default).
- Throughput, with `rsp_ready` held high:
  - Non-mult: one op every 2 cycles.
  - mult: one op every DATA_WIDTH/2 + 2 cycles.
- Reset asserted mid-MUL or in DONE: the FSM returns to IDLE immediately, the partial product is discarded and outputs take their reset values. No response is emitted for the aborted request.
- `req_valid` without acceptance (MUL/DONE): no effect; the requester must hold the request.

## Configuration
- `WALU_MC_OVF_EN` defined: adds output port `rsp_ovf` (1 bit, reset 0).
  - Set to signed two's-complement overflow for add and sub.
  - Set to 1 for mult when the iterative product differs from the full unsigned product of the complete operands truncated to DATA_WIDTH.
  - 0 for all other ops.
  - Valid and stable with `rsp_data`.
- Not defined: port absent, overflow logic not synthesized, all other behaviour identical.

## Test plan
- Reset, then `add` a=0xFFFF_FFFF b=0x0000_0002 → one cycle later `rsp_valid`=1, `rsp_data`=0x0000_0001, `rsp_err`=0. With `WALU_MC_OVF_EN`, `rsp_ovf`=0.
- `mult` a=0xABCD_1234 b=0x0000_0100 → `req_ready` low for 16 cycles, `rsp_valid` on cycle 17, `rsp_data`=0x0012_3400.
- `funcrr` a=0x8000_0001 b=0x0000_0021 (amount 1) → `rsp_data`=0xC000_0000. `funclsl` same operands → 0x0000_0002.
- Op code 12 with arbitrary operands → `rsp_data`=0, `rsp_err`=1. The next `sub` 5−7 → 0xFFFF_FFFE, `rsp_err`=0.
- Backpressure: hold `rsp_ready`=0 for 10 cycles after a `bitxor` 0xF0F0_F0F0 ^ 0xFFFF_0000 → `rsp_data` stays 0x0F0F_F0F0, `req_ready`=0 throughout, single transfer on release.
- Assert `rst_n`=0 during cycle 8 of a mult → `rsp_valid` never rises for it. After release, `add` 1+1 returns 2 with normal latency.
